instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage: holds the program counter, reads the instruction memory, and presents `inst` and `pc_seq` combinationally to the execute stage every cycle. It consumes `branch`, `jump` and `zero` back from execute and computes the next PC. It also provides:
- a bench load port for the instruction memory;
- a halt state machine;
- a retired-instruction counter.

## Interface
Parameters:
- `IMEM_DEPTH`, 1024: instruction memory depth in 32-bit words; power of two.
- `AW`, 10: word-address width, `log2(IMEM_DEPTH)`.
- `RESET_PC`, 30'd0: word address loaded into the PC on reset.
- `HALT_OPCODE`, 6'b111111: opcode that stops fetch.

Ports:
- `clk`  in  1  system clock. PC and state update on posedge; execute writes on negedge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold PC, state and counter this cycle.
- `branch`  in  1  from execute: current instruction is a conditional branch (beq).
- `jump`  in  1  from execute: current instruction is j/jal.
- `zero`  in  1  from execute: ALU zero flag.
- `load_en`  in  1  instruction-memory write enable.
- `load_addr`  in  AW  word address for the write.
- `load_data`  in  32  instruction word to write.
- `inst`  out  32  instruction for execute.
- `pc`  out  30  current PC, word address.
- `pc_seq`  out  30  `pc + 1` (wraps mod 2^30); used by execute as the jal link.
- `halted`  out  1  high while in HALTED.
- `inst_count`  out  32  number of retired instructions.

## Operation
- States:
  - RESET: `reset` high.
  - RUN.
  - HALTED.
- RESET → RUN on the first posedge with `reset` low.
- RUN → HALTED on a posedge where `stall`=0 and either:
  - `inst[31:26]==HALT_OPCODE`; or
  - `pc >= IMEM_DEPTH` (out-of-range fetch).
- HALTED is left only via `reset`.
- Instruction memory is an array of `IMEM_DEPTH` × 32 bits:
  - zero-initialised at time 0;
  - not cleared by `reset`;
  - asynchronous read at `pc[AW-1:0]`.
- `inst` output:
  - in RUN with `pc < IMEM_DEPTH`: the memory word;
  - otherwise (RESET, HALTED, out-of-range): 32'h0, i.e. sll $0 nop.
- Next PC in RUN with `stall`=0, evaluated in priority order:
  1. halt condition: PC holds;
  2. `jump`: `{pc_seq[29:26], inst[25:0]}`;
  3. `branch & zero`: `pc_seq + sign_extend30(inst[15:0])`, 30-bit wrap;
  4. else: `pc_seq`.
- `branch` with `zero`=0 falls through to `pc_seq`.
- `stall`=1: PC, state and `inst_count` all hold. Outputs stay stable for the whole held cycle.
- `inst_count` increments by 1 on each RUN posedge with `stall`=0 and no halt condition:
  - the halt instruction itself is not counted;
  - wraps at 2^32.
- Load port:
  - a write to `mem[load_addr]` happens on posedge only when `reset`=1 or state is HALTED;
  - `load_en` in RUN is ignored.

## Timing
- Reset values: PC = `RESET_PC`, `pc_seq` = `RESET_PC+1`, `inst` = 0, `halted` = 0, `inst_count` = 0.
- `inst`, `pc` and `pc_seq` are combinational from the PC register. They are valid before the negedge on which execute commits register and memory writes.
- Redirect latency:
  - `branch`/`jump`/`zero` sampled at posedge N;
  - target visible on `pc`/`inst` right after posedge N;
  - zero bubbles; no delay slot.
- `halted` rises the cycle after the posedge that sees the halt condition. From that point `inst` reads 0.
- Reset mid-operation: at the next posedge, state → RESET and all outputs take their reset values. Pending redirects are discarded.
- `stall` together with `jump` or a taken branch: `stall` wins, and the redirect is re-evaluated next cycle from the same `inst`.
- A load write to the address currently being fetched is visible on `inst` after that posedge.

## Test plan
- **Sequential fetch.** Load words 0..3 with addi instructions, release reset, run 4 cycles → `pc` = 0, 1, 2, 3; `pc_seq` = 1, 2, 3, 4; `inst_count` = 4.
- **Branch.**
  - `pc`=5 holding beq with imm16=16'hFFFD, `branch`=1, `zero`=1 → next `pc` = 3.
  - Same with `zero`=0 → next `pc` = 6.
- **Jump.** `pc`=2 holding j with target=26'd40, `jump`=1 → next `pc` = 40. Priority check: `jump` and `branch`+`zero` asserted together → `pc` = 40.
- **Stall.** Assert `stall` for 3 cycles at `pc`=7 with `jump`=1 → `pc` stays 7 and `inst_count` unchanged. After release, the next posedge jumps.
- **Halt.**
  - HALT_OPCODE word at address 4 → `halted`=1 after the posedge at `pc`=4, `inst`=0, `pc` stays 4, `inst_count` = 4.
  - `load_en` in RUN has no effect.
  - In HALTED, a write to address 4 takes effect.
- **Reset and out-of-range.**
  - Reset asserted mid-run at `pc`=9 → next cycle `pc`=0, `inst_count`=0, memory contents intact.
  - Jump to 1024 with `IMEM_DEPTH`=1024 → `inst`=0, then `halted`=1.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, instruction memory,
// halt state machine and retired-instruction counter.
module instruction_fetch #(
    parameter int          IMEM_DEPTH  = 1024,
    parameter int          AW          = 10,
    parameter logic [29:0] RESET_PC    = 30'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch,
    input  logic          jump,
    input  logic          zero,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [31:0]   inst,
    output logic [29:0]   pc,
    output logic [29:0]   pc_seq,
    output logic          halted,
    output logic [31:0]   inst_count
);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;

    // Zero at power-up; reset deliberately leaves contents alone.
    logic [31:0] mem_q [IMEM_DEPTH] = '{default: '0};

    logic        run;
    logic        in_range;
    logic        halt_cond;
    logic [29:0] seq;
    logic [29:0] br_tgt;
    logic [29:0] j_tgt;
    logic [31:0] rd_word;

    assign run      = (state_q == S_RUN);
    assign in_range = ({2'b00, pc_q} < 32'(IMEM_DEPTH));
    assign seq      = pc_q + 30'd1;
    assign rd_word  = mem_q[pc_q[AW-1:0]];

    // Anything outside RUN or past the memory end fetches a nop.
    assign inst = (run && in_range) ? rd_word : 32'h0;

    assign halt_cond = run &&
                       (!in_range || inst[31:26] == HALT_OPCODE);

    assign br_tgt = seq + {{14{inst[15]}}, inst[15:0]};
    assign j_tgt  = {seq[29:26], inst[25:0]};

    assign pc         = pc_q;
    assign pc_seq     = seq;
    assign halted     = (state_q == S_HALTED);
    assign inst_count = cnt_q;

    // Next state, PC and retire count; stall freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_RESET: begin
                if (!stall) state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (halt_cond) begin
                        state_d = S_HALTED;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        if (jump)
                            pc_d = j_tgt;
                        else if (branch && zero)
                            pc_d = br_tgt;
                        else
                            pc_d = seq;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loader may only write while the core is not running.
    always_ff @(posedge clk) begin
        if (load_en && (reset || state_q == S_HALTED))
            mem_q[load_addr] <= load_data;
    end

endmodule
